// File: rtl/addsub_pkg.sv
// addsub_pkg: shared widths, stage-count helper and opcodes for the pipelined adder/subtractor
package addsub_pkg;
    localparam int N_DEF = 32;
    localparam int GROUP_DEF = 8;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int stages(input int n, input int g);
        return n / g;
    endfunction
endpackage

// File: rtl/addsub_stage.sv
// addsub_stage: one GROUP-bit carry-increment slice plus its elastic pipeline register
module addsub_stage #(
    parameter int N = 32,
    parameter int GROUP = 8,
    parameter int K = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         prev_valid,
    input  logic         next_ld,
    input  logic [N-1:0] prev_a,
    input  logic [N-1:0] prev_b,
    input  logic [N-1:0] prev_s,
    input  logic         prev_c,
    input  logic         prev_sa,
    input  logic         prev_sb,
    output logic         ld,
    output logic         valid,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         c,
    output logic         sa,
    output logic         sb,
    output logic         ovf
);
    localparam int LO = K * GROUP;
    // Only operand bits above this slice travel on; the rest are already resolved
    localparam logic [N-1:0] KEEP = {N{1'b1}} << ((K + 1) * GROUP);

    logic [GROUP:0] r0, r1, r;
    logic [N-1:0]   ns;

    always_comb begin
        r0 = {1'b0, prev_a[LO +: GROUP]} + {1'b0, prev_b[LO +: GROUP]};
        r1 = r0 + 1'b1;
        r  = prev_c ? r1 : r0;
        ns = prev_s;
        ns[LO +: GROUP] = r[GROUP-1:0];
    end

    assign ld = !valid || next_ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            a     <= '0;
            b     <= '0;
            s     <= '0;
            c     <= 1'b0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            ovf   <= 1'b0;
        end else if (ld) begin
            valid <= prev_valid;
            if (prev_valid) begin
                a   <= prev_a & KEEP;
                b   <= prev_b & KEEP;
                s   <= ns;
                c   <= r[GROUP];
                sa  <= prev_sa;
                sb  <= prev_sb;
                ovf <= (prev_sa == prev_sb) && (ns[N-1] != prev_sa);
            end
        end
    end
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: elastic N-bit add/sub, one GROUP-bit slice resolved per pipeline stage
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int GROUP = GROUP_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int STAGES = stages(N, GROUP);

    if (N % GROUP != 0) begin : g_chk
        $error("N must be a multiple of GROUP");
    end

    logic         vp  [STAGES+1];
    logic         ld  [STAGES+1];
    logic         cp  [STAGES+1];
    logic         sap [STAGES+1];
    logic         sbp [STAGES+1];
    logic [N-1:0] ap  [STAGES+1];
    logic [N-1:0] bp  [STAGES+1];
    logic [N-1:0] sp  [STAGES+1];
    logic         ovp [STAGES];
    logic [N-1:0] bx;

    // Subtract is a + ~b + 1: invert once up front, force the carry-in
    assign bx         = (sub == OP_SUB) ? ~b : b;
    assign vp[0]      = in_valid;
    assign ap[0]      = a;
    assign bp[0]      = bx;
    assign sp[0]      = '0;
    assign cp[0]      = (sub == OP_SUB) ? 1'b1 : cin;
    assign sap[0]     = a[N-1];
    assign sbp[0]     = bx[N-1];
    assign ld[STAGES] = out_ready;

    assign in_ready  = ld[0];
    assign out_valid = vp[STAGES];
    assign sum       = sp[STAGES];
    assign cout      = cp[STAGES];
    assign ovf       = ovp[STAGES-1];

    for (genvar i = 0; i < STAGES; i++) begin : g_st
        addsub_stage #(.N(N), .GROUP(GROUP), .K(i)) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_valid (vp[i]),
            .next_ld    (ld[i+1]),
            .prev_a     (ap[i]),
            .prev_b     (bp[i]),
            .prev_s     (sp[i]),
            .prev_c     (cp[i]),
            .prev_sa    (sap[i]),
            .prev_sb    (sbp[i]),
            .ld         (ld[i]),
            .valid      (vp[i+1]),
            .a          (ap[i+1]),
            .b          (bp[i+1]),
            .s          (sp[i+1]),
            .c          (cp[i+1]),
            .sa         (sap[i+1]),
            .sb         (sbp[i+1]),
            .ovf        (ovp[i])
        );
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vectors plus an arithmetic reference model scoreboard
module tb_pipelined_addsub;
    localparam int N = 32;
    localparam int STAGES = 4;
    localparam longint MAXS = (longint'(1) << (N - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (N - 1));

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;
    int nout = 0;
    logic [N+1:0] q[$];

    pipelined_addsub #(.N(N), .GROUP(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic ck(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    // {ovf, cout, sum} from plain unsigned and signed arithmetic
    function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic ci, input logic op);
        logic [N:0] r;
        longint sr;
        if (op) begin
            r  = {1'b0, x} + {1'b0, ~y} + 1'b1;
            sr = longint'($signed(x)) - longint'($signed(y));
        end else begin
            r  = {1'b0, x} + {1'b0, y} + ci;
            sr = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        end
        return {(sr > MAXS) || (sr < MINS), r};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    ck("unexpected_out", out_valid, 0);
                end else begin
                    ck("model", {ovf, cout, sum}, q[0]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        nout++;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tc, input logic ts);
        int n;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ck("send_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic expect_out(input logic [N-1:0] es, input logic ec, input logic eo);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        ck("latency", n, STAGES - 1);
        ck("sum", sum, es);
        ck("cout", cout, ec);
        ck("ovf", ovf, eo);
    endtask

    initial begin
        int acc, cyc, n0, n;
        logic got;
        repeat (2) @(posedge clk);
        #1;
        ck("rst_out_valid", out_valid, 0);
        ck("rst_sum", sum, 0);
        rst_n = 1'b1;
        @(negedge clk);
        ck("init_in_ready", in_ready, 1);
        ck("init_out_valid", out_valid, 0);
        ck("init_cout_ovf", {cout, ovf}, 0);
        @(posedge clk);
        #1;

        send(32'h00003A9A, 32'h0000E544, 1'b1, 1'b0);
        expect_out(32'h00011FDF, 1'b0, 1'b0);
        send(32'hD47856ED, 32'hDCBE1597, 1'b1, 1'b0);
        expect_out(32'hB1366C85, 1'b1, 1'b0);
        send(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
        expect_out(32'h80000000, 1'b0, 1'b1);
        send(32'd856, 32'd521, 1'b0, 1'b1);
        expect_out(32'd335, 1'b1, 1'b0);
        send(32'd521, 32'd856, 1'b1, 1'b1);
        expect_out(32'hFFFFFEB1, 1'b0, 1'b0);
        send(32'h80000000, 32'h1, 1'b0, 1'b1);
        expect_out(32'h7FFFFFFF, 1'b1, 1'b1);

        // Back-to-back stream
        @(posedge clk);
        #1;
        n0 = nout;
        for (int i = 0; i < 20; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
            @(negedge clk);
            ck("stream_in_ready", in_ready, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ck("stream_count", nout - n0, 20);

        // Backpressure fill
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            a = 32'(521 + acc); b = 32'd856; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) acc++;
        end
        ck("bp_accepted", acc, STAGES);
        ck("bp_in_ready", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < STAGES; j++) begin
            @(negedge clk);
            ck("bp_valid", out_valid, 1);
            ck("bp_sum", sum, 1378 + j);
            @(posedge clk);
            #1;
        end

        // Random in_valid / out_ready
        acc = 0; cyc = 0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        while (acc < 200 && cyc < 5000) begin
            out_ready = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            got = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (got) begin
                acc++;
                a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            end
            cyc++;
        end
        ck("rand_accepted", acc, 200);
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        ck("rand_drain", q.size(), 0);

        // Reset with beats in flight
        out_ready = 1'b0;
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        send(32'h00000005, 32'h00000009, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        ck("pre_rst_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        ck("async_valid", out_valid, 0);
        ck("async_sum", sum, 0);
        ck("async_cout", cout, 0);
        ck("async_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        ck("post_rst_in_ready", in_ready, 1);
        ck("post_rst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        send(32'd521, 32'd856, 1'b1, 1'b0);
        expect_out(32'd1378, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        ck("final_queue", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
